// File: rtl/accum_result_serializer_pkg.sv
// Shared types and geometry for the accumulator result serializer.
// A burst is 4 tiles x 4 rows x 4 columns of complex samples.
package accum_result_serializer_pkg;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } complex_t;

  localparam int TILES = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int BEATS = 16;

  typedef complex_t [0:COLS-1] complex_row_t;
  typedef complex_t [0:TILES-1][0:ROWS-1][0:COLS-1] complex_tile_set_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } drain_state_e;

  function automatic logic is_last_beat(input logic [3:0] cnt);
    return cnt == 4'(BEATS - 1);
  endfunction

endpackage

// File: rtl/accum_result_serializer_if.sv
// Row-beat valid/ready stream from the serializer to the writeback stage.
interface accum_result_serializer_if;
  import accum_result_serializer_pkg::*;

  complex_row_t out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_tile;
  logic [1:0]   out_row;
  logic         out_last;

  modport master (
    output out_data, out_valid, out_tile, out_row, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_tile, out_row, out_last,
    output out_ready
  );
endinterface

// File: rtl/accum_result_serializer_result_bank.sv
// One buffer bank: holds a whole captured burst plus its full flag,
// and exposes one row of four samples selected by tile/row.
module result_bank
  import accum_result_serializer_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic              i_clr,
  input  complex_tile_set_t i_data,
  input  logic [1:0]        i_tile,
  input  logic [1:0]        i_row,
  output complex_row_t      o_row,
  output logic              o_full
);

  complex_tile_set_t r_data;
  logic              r_full;

  // Capture wins over clear so a bank freed and refilled in one cycle stays full.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_full <= 1'b0;
    end else if (i_we) begin
      r_full <= 1'b1;
    end else if (i_clr) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_data <= i_data;
    end
  end

  assign o_row  = r_data[i_tile][i_row];
  assign o_full = r_full;

endmodule

// File: rtl/accum_result_serializer.sv
// Double-buffers accumulator result bursts and drains each as 16 row-beats
// over a valid/ready stream; sticky overflow flags a burst that found no room.
module accum_result_serializer
  import accum_result_serializer_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  complex_tile_set_t         i_in,
  input  logic                      i_in_valid,
  accum_result_serializer_if.master bus,
  output logic                      o_can_accept,
  output logic                      o_overflow
);

  drain_state_e r_state, w_state_next;
  logic         r_wr_bank, r_rd_bank, w_wr_next, w_rd_next;
  logic [3:0]   r_cnt, w_cnt_next;
  logic         r_overflow;
  logic [1:0]   w_full, w_we, w_clr, w_full_next;
  logic         w_xfer, w_last_xfer, w_drop;
  complex_row_t w_row0, w_row1;

  result_bank u_bank0 (
    .i_clk(i_clk), .i_reset(i_reset), .i_we(w_we[0]), .i_clr(w_clr[0]),
    .i_data(i_in), .i_tile(r_cnt[3:2]), .i_row(r_cnt[1:0]),
    .o_row(w_row0), .o_full(w_full[0])
  );

  result_bank u_bank1 (
    .i_clk(i_clk), .i_reset(i_reset), .i_we(w_we[1]), .i_clr(w_clr[1]),
    .i_data(i_in), .i_tile(r_cnt[3:2]), .i_row(r_cnt[1:0]),
    .o_row(w_row1), .o_full(w_full[1])
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_cnt      <= 4'd0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wr_bank  <= w_wr_next;
      r_rd_bank  <= w_rd_next;
      r_cnt      <= w_cnt_next;
      r_overflow <= r_overflow | w_drop;
    end
  end

  // A bank freed by the last beat this cycle counts as empty for capture.
  always_comb begin
    w_clr     = 2'b00;
    w_we      = 2'b00;
    w_drop    = 1'b0;
    w_wr_next = r_wr_bank;
    w_rd_next = r_rd_bank;
    w_cnt_next = r_cnt;

    w_xfer      = (r_state == ST_STREAM) && bus.out_ready;
    w_last_xfer = w_xfer && is_last_beat(r_cnt);

    if (w_last_xfer) begin
      w_clr[r_rd_bank] = 1'b1;
      w_rd_next        = ~r_rd_bank;
      w_cnt_next       = 4'd0;
    end else if (w_xfer) begin
      w_cnt_next = r_cnt + 4'd1;
    end else begin
      w_cnt_next = r_cnt;
    end

    if (i_in_valid) begin
      if (!w_full[r_wr_bank] || w_clr[r_wr_bank]) begin
        w_we[r_wr_bank] = 1'b1;
        w_wr_next       = ~r_wr_bank;
      end else begin
        w_drop = 1'b1;
      end
    end else begin
      w_drop = 1'b0;
    end

    w_full_next  = w_we | (w_full & ~w_clr);
    w_state_next = w_full_next[w_rd_next] ? ST_STREAM : ST_IDLE;
  end

  always_comb begin
    bus.out_valid = (r_state == ST_STREAM);
    bus.out_tile  = r_cnt[3:2];
    bus.out_row   = r_cnt[1:0];
    bus.out_last  = bus.out_valid && is_last_beat(r_cnt);
    if (bus.out_valid) begin
      bus.out_data = r_rd_bank ? w_row1 : w_row0;
    end else begin
      bus.out_data = '0;
    end
  end

  assign o_can_accept = ~(w_full[0] & w_full[1]);
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_accum_result_serializer.sv
// Scoreboard bench: stimulus pushes expected row-beats, a negedge monitor
// compares every presented beat against the queue head and pops on transfer.
module tb_accum_result_serializer;
  import accum_result_serializer_pkg::*;

  typedef struct packed {
    logic [1:0]   tile;
    logic [1:0]   row;
    logic         last;
    complex_row_t data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  complex_tile_set_t in_data;
  logic              in_valid;
  logic              can_accept;
  logic              overflow;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   beats = 0;
  int   run_len = 0;
  int   max_run = 0;
  logic rnd_mode = 1'b0;
  logic prev_stall = 1'b0;

  accum_result_serializer_if u_if();

  accum_result_serializer dut (
    .i_clk(clk), .i_reset(reset), .i_in(in_data), .i_in_valid(in_valid),
    .bus(u_if), .o_can_accept(can_accept), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic complex_t make_val(input int v);
    complex_t x;
    x.re = 32'(v);
    x.im = 32'(-v);
    return x;
  endfunction

  task automatic load_burst(input int base);
    for (int t = 0; t < 4; t++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          in_data[t[1:0]][r[1:0]][c[1:0]] = make_val(base + 16 * t + 4 * r + c);
  endtask

  task automatic push_burst(input int base);
    exp_t e;
    for (int t = 0; t < 4; t++)
      for (int r = 0; r < 4; r++) begin
        e.tile = t[1:0];
        e.row  = r[1:0];
        e.last = (t == 3) && (r == 3);
        for (int c = 0; c < 4; c++)
          e.data[c[1:0]] = make_val(base + 16 * t + 4 * r + c);
        exp_q.push_back(e);
      end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int base, input logic expect_capture);
    load_burst(base);
    in_valid = 1'b1;
    if (expect_capture) push_burst(base);
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      cycle();
      n++;
    end
    check("drain_complete", 256'(exp_q.size() == 0), 256'(1));
    cycle();
    cycle();
    check("idle_after_drain", 256'(u_if.out_valid), 256'(0));
  endtask

  // Monitor: compares the presented beat to the queue head, pops on transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
        run_len    = 0;
      end else begin
        if (prev_stall) check("valid_held", 256'(u_if.out_valid), 256'(1));
        if (u_if.out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 256'(1), 256'(0));
          end else begin
            check("beat_tile", 256'(u_if.out_tile), 256'(exp_q[0].tile));
            check("beat_row",  256'(u_if.out_row),  256'(exp_q[0].row));
            check("beat_last", 256'(u_if.out_last), 256'(exp_q[0].last));
            check("beat_data", 256'(u_if.out_data), 256'(exp_q[0].data));
            if (u_if.out_ready) begin
              void'(exp_q.pop_front());
              beats++;
            end
          end
          run_len++;
          if (run_len > max_run) max_run = run_len;
        end else begin
          run_len = 0;
        end
        prev_stall = u_if.out_valid && !u_if.out_ready;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_mode) u_if.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    u_if.out_ready = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    check("rst_valid",      256'(u_if.out_valid), 256'(0));
    check("rst_last",       256'(u_if.out_last),  256'(0));
    check("rst_tile",       256'(u_if.out_tile),  256'(0));
    check("rst_row",        256'(u_if.out_row),   256'(0));
    check("rst_data",       256'(u_if.out_data),  256'(0));
    check("rst_overflow",   256'(overflow),       256'(0));
    check("rst_can_accept", 256'(can_accept),     256'(1));

    // Single burst, one-cycle latency.
    u_if.out_ready = 1'b1;
    pulse(0, 1'b1);
    check("latency_valid", 256'(u_if.out_valid), 256'(1));
    wait_drain(100);
    check("single_overflow", 256'(overflow), 256'(0));

    // Random back-pressure.
    b0 = beats;
    rnd_mode = 1'b1;
    pulse(50, 1'b1);
    wait_drain(400);
    rnd_mode = 1'b0;
    u_if.out_ready = 1'b1;
    check("bp_transfers", 256'(beats - b0), 256'(16));

    // Double buffer: B three cycles after A.
    max_run = 0;
    pulse(100, 1'b1);
    cycle();
    cycle();
    pulse(200, 1'b1);
    check("dbl_can_accept_full", 256'(can_accept), 256'(0));
    for (int i = 0; i < 12; i++) cycle();
    check("dbl_can_accept_pre", 256'(can_accept), 256'(0));
    cycle();
    check("dbl_can_accept_post", 256'(can_accept), 256'(1));
    wait_drain(100);
    check("dbl_contiguous", 256'(max_run), 256'(32));

    // Overflow: third burst dropped.
    u_if.out_ready = 1'b0;
    pulse(300, 1'b1);
    cycle();
    pulse(400, 1'b1);
    check("ovf_can_accept", 256'(can_accept), 256'(0));
    check("ovf_before_c",   256'(overflow),   256'(0));
    cycle();
    pulse(600, 1'b0);
    check("ovf_after_c", 256'(overflow), 256'(1));
    u_if.out_ready = 1'b1;
    wait_drain(100);
    check("ovf_sticky", 256'(overflow), 256'(1));
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("ovf_cleared", 256'(overflow), 256'(0));

    // C arrives on A's last-beat transfer with both banks full.
    u_if.out_ready = 1'b0;
    pulse(700, 1'b1);
    pulse(800, 1'b1);
    check("sim_both_full", 256'(can_accept), 256'(0));
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 15; i++) cycle();
    pulse(900, 1'b1);
    check("sim_no_overflow", 256'(overflow), 256'(0));
    wait_drain(100);
    check("sim_no_overflow_end", 256'(overflow), 256'(0));
    check("sim_can_accept_end",  256'(can_accept), 256'(1));

    // Reset while beat 7 is presented; in_valid during reset is ignored.
    pulse(1000, 1'b1);
    for (int i = 0; i < 7; i++) cycle();
    check("rmd_consumed", 256'(exp_q.size()), 256'(9));
    reset = 1'b1;
    u_if.out_ready = 1'b0;
    load_burst(1100);
    in_valid = 1'b1;
    exp_q.delete();
    cycle();
    reset = 1'b0;
    in_valid = 1'b0;
    check("rmd_valid",      256'(u_if.out_valid), 256'(0));
    check("rmd_can_accept", 256'(can_accept),     256'(1));
    check("rmd_tile",       256'(u_if.out_tile),  256'(0));
    cycle();
    check("rmd_ignored_in", 256'(u_if.out_valid), 256'(0));
    u_if.out_ready = 1'b1;
    pulse(1200, 1'b1);
    check("rmd_new_valid", 256'(u_if.out_valid), 256'(1));
    check("rmd_new_row",   256'(u_if.out_row),    256'(0));
    wait_drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/accum_result_serializer.md
# accum_result_serializer

Captures the full 4×4×4 complex result burst from the parallel accumulator array when its `output_valid` pulses. Holds up to two bursts in a two-bank register buffer. Drains each burst as 16 row-beats of four `complex_t` values over a valid/ready stream toward the inverse-transform / writeback stage. Decouples the non-stallable accumulator from the back-pressured downstream and flags any dropped burst.

## Interface
- No parameters; geometry fixed at 4 tiles × 4 rows × 4 columns; `complex_t` (fp32 real, fp32 imag) from `common.vh`.
- `clk`  in  1  sole clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in`  in  complex_t [0:3][0:3][0:3]  accumulator result, indexed [tile][row][col].
- `in_valid`  in  1  single-cycle capture strobe (accumulator `output_valid`).
- `out`  out  complex_t [0:3]  one row: `out[c]` = captured `[tile][row][c]`.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  downstream accepts beat.
- `out_tile`  out  2  tile index of current beat.
- `out_row`  out  2  row index of current beat.
- `out_last`  out  1  high on beat 15 of a burst (tile 3, row 3).
- `can_accept`  out  1  at least one bank empty (status only; accumulator cannot stall).
- `overflow`  out  1  sticky; a burst was dropped.

## Operation
- Two banks (0, 1), each 64 `complex_t` plus a `full` flag. Write pointer `wr_bank` and read pointer `rd_bank` are 1-bit, toggle after each capture or drain.
- Capture: `in_valid` with bank[`wr_bank`] not full -> store all 64 values, set full, toggle `wr_bank`.
- Drop: `in_valid` with bank[`wr_bank`] full and not freed this cycle -> no write, pointers unchanged, `overflow` <= 1 until reset.
- Drain: 4-bit beat counter `cnt`. While bank[`rd_bank`] full: `out_valid`=1, `out_tile`=`cnt[3:2]`, `out_row`=`cnt[1:0]`, `out` = bank[`rd_bank`][tile][row][0:3].
- Handshake: a beat transfers when `out_valid && out_ready`; `cnt` increments.
- On transfer with `cnt`=15: clear bank full, toggle `rd_bank`, `cnt` <= 0.
- Order is tile-major, then row: (0,0),(0,1)…(3,3).
- Drain FSM, derived from `rd_bank` full:
  - IDLE (`out_valid`=0) -> STREAM when bank[`rd_bank`] becomes full.
  - STREAM -> IDLE after the last beat if the other bank is empty; otherwise stays in STREAM on the other bank with no bubble.
- Simultaneous last-beat transfer and `in_valid` while both banks full: the freed bank is written in that same cycle. No drop, no overflow.
- Data passes unchanged; no arithmetic.

## Timing
- Reset values:
  - `out_valid`=0, `out_last`=0, `out_tile`=0, `out_row`=0, `out`=0.
  - `overflow`=0, `can_accept`=1.
  - Both banks empty, `wr_bank`=`rd_bank`=0, `cnt`=0.
- Latency: `in_valid` at cycle N -> `out_valid` high at N+1 if idle. First beat holds capture-cycle data.
- With `out_ready` held high, a burst drains in 16 consecutive cycles. Back-to-back bursts give 32 consecutive beats.
- `out`, `out_tile`, `out_row` and `out_last` hold stable while `out_valid && !out_ready`.
- `out_valid` never drops without a transfer, except on reset.
- `can_accept` updates the cycle after a capture or drain completes.
- Reset mid-burst discards all buffered data; the next cycle behaves as post-reset.
- `in_valid` asserted during reset is ignored.

## Structure
- `complex_t` stays in the shared `common.vh`.
- Add to the shared package: constants `TILES=4`, `ROWS=4`, `COLS=4`, `BEATS=16`, and typedef `complex_tile_set_t` = complex_t [0:3][0:3][0:3].
- One natural sub-module, `result_bank`: a 64-entry register with capture enable, full flag, clear, and a row-select read port. Instantiate it twice.

## Test plan
- Single burst: `in[t][r][c]` real = 16t+4r+c, imag = −(same); `in_valid` one cycle; `out_ready`=1.
  - Expect 16 beats starting N+1, with `out[c]` matching `[t][r][c]`.
  - `out_last` only on beat 15; `overflow`=0.
- Back-pressure: toggle `out_ready` pseudo-randomly during a burst.
  - Outputs stay stable while stalled.
  - Exactly 16 transfers in order, no duplicates or skips.
- Double buffer: two bursts A, B 3 cycles apart, `out_ready`=1.
  - Expect 32 contiguous beats, A then B.
  - `can_accept` goes 0 after B's capture and 1 after A drains.
- Overflow: `out_ready`=0, three bursts A, B, C.
  - C is dropped and `overflow`=1 from the cycle after C.
  - Releasing `out_ready` yields A then B only.
- Simultaneous free/capture: both banks full; C arrives on the same cycle as A's last-beat transfer.
  - Expect no overflow, and B then C drained.
- Reset mid-drain: assert `reset` at beat 7.
  - Next cycle `out_valid`=0 and `can_accept`=1.
  - A new burst drains from beat 0 with new data.
